// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller and its decode buffer.
package if_fetch_ctrl_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int INSTR_BYTES = 4;
  localparam int IBUF_DEPTH  = 2;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } state_t;

endpackage

// File: rtl/if_ibuf.sv
// Two-entry in-order instruction buffer between fetch and decode.
// Entry e0 is always the head; a pop shifts e1 down into e0.
module if_ibuf #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [0:PC_WIDTH-1]    push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic [1:0]             count,
  output logic                   head_valid,
  output logic [0:PC_WIDTH-1]    head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr
);
  import if_fetch_ctrl_pkg::*;

  logic [0:PC_WIDTH-1]    e0_pc;
  logic [0:PC_WIDTH-1]    e1_pc;
  logic [INSTR_WIDTH-1:0] e0_instr;
  logic [INSTR_WIDTH-1:0] e1_instr;
  logic                   push_ok;
  logic                   pop_ok;

  assign push_ok    = push && (count != 2'(IBUF_DEPTH));
  assign pop_ok     = pop && head_valid;
  assign head_valid = (count != 2'd0);
  assign head_pc    = e0_pc;
  assign head_instr = e0_instr;

  // Storage and occupancy; a flush wins over everything, including a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      e0_pc    <= '0;
      e1_pc    <= '0;
      e0_instr <= '0;
      e1_instr <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            e0_pc    <= push_pc;
            e0_instr <= push_instr;
          end else begin
            e1_pc    <= push_pc;
            e1_instr <= push_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e0_pc    <= e1_pc;
          e0_instr <= e1_instr;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_pc    <= push_pc;
            e0_instr <= push_instr;
          end else begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
            e1_pc    <= push_pc;
            e1_instr <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the IMEM port from the PC register,
// returns NPC/PCWr, handles redirects and feeds a two-entry decode buffer.
module if_fetch_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [0:PC_WIDTH-1] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [0:PC_WIDTH-1]    PC,
  output logic                   PCWr,
  output logic [0:PC_WIDTH-1]    NPC,
  output logic                   imem_req,
  output logic [0:PC_WIDTH-1]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [0:PC_WIDTH-1]    redirect_target,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [0:PC_WIDTH-1]    id_pc,
  input  logic                   id_ready
);
  import if_fetch_ctrl_pkg::*;

  state_t              state;
  logic                outstanding;
  logic [0:PC_WIDTH-1] addr_q;
  logic [1:0]          count;
  logic                held;
  logic                ack_accept;
  logic                pop;
  logic                first_cycle;

  // A request is "held" while its ack is still owed, whether it will be kept or dropped.
  assign held       = (state == S_DROP) || outstanding;
  assign imem_req   = rst_n && (held || (count < 2'(IBUF_DEPTH)));
  assign imem_addr  = held ? addr_q : PC;
  assign ack_accept = (state == S_REQ) && imem_req && imem_ack && !redirect_valid;
  assign pop        = id_valid && id_ready;
  assign PCWr       = rst_n && (redirect_valid || ack_accept);
  assign NPC        = redirect_valid ? (redirect_target & ~PC_WIDTH'(INSTR_BYTES - 1)) :
                      ack_accept     ? (imem_addr + PC_WIDTH'(INSTR_BYTES)) :
                                       (PC + PC_WIDTH'(INSTR_BYTES));

  // Fetch FSM: tracks the owed ack and whether its data must be thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      outstanding <= 1'b0;
      addr_q      <= '0;
    end else begin
      if (!held) begin
        addr_q <= PC;
      end
      case (state)
        S_REQ: begin
          if (imem_req) begin
            if (imem_ack) begin
              outstanding <= 1'b0;
            end else if (redirect_valid) begin
              state       <= S_DROP;
              outstanding <= 1'b0;
            end else begin
              outstanding <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_ibuf #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_ibuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ack_accept),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (imem_addr),
    .push_instr (imem_rdata),
    .count      (count),
    .head_valid (id_valid),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

  // Marks the first clock after reset release so the PC register reset value can be checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_cycle <= 1'b1;
    end else begin
      first_cycle <= 1'b0;
    end
  end

  a_ack_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_ack |-> imem_req);
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(ack_accept && (count == 2'(IBUF_DEPTH))));
  a_reset_pc: assert property (@(posedge clk) disable iff (!rst_n)
    first_cycle |-> (PC == RESET_PC));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a behavioural PC register alongside it.
module tb_if_fetch_ctrl;

  localparam logic [0:31] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] pc;
  logic        pc_wr;
  logic [0:31] npc;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [0:31] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [0:31] id_pc;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The PC register the controller talks to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_wr) begin
      pc <= npc;
    end
  end

  if_fetch_ctrl #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC              (pc),
    .PCWr            (pc_wr),
    .NPC             (npc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_ready        (id_ready)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ack, input logic [31:0] rdata, input logic redir,
                                input logic [31:0] target, input logic ready);
    imem_ack        = ack;
    imem_rdata      = rdata;
    redirect_valid  = redir;
    redirect_target = target;
    id_ready        = ready;
    #1;
  endtask

  task automatic check_fetch(input string step, input logic req, input logic [31:0] addr,
                             input logic wr, input logic [31:0] next_pc);
    check_output($sformatf("%s.imem_req", step), 64'(imem_req), 64'(req));
    check_output($sformatf("%s.imem_addr", step), 64'(imem_addr), 64'(addr));
    check_output($sformatf("%s.PCWr", step), 64'(pc_wr), 64'(wr));
    if (wr) begin
      check_output($sformatf("%s.NPC", step), 64'(npc), 64'(next_pc));
    end
  endtask

  task automatic check_id(input string step, input logic valid, input logic [31:0] head_pc,
                          input logic [31:0] head_instr);
    check_output($sformatf("%s.id_valid", step), 64'(id_valid), 64'(valid));
    if (valid) begin
      check_output($sformatf("%s.id_pc", step), 64'(id_pc), 64'(head_pc));
      check_output($sformatf("%s.id_instr", step), 64'(id_instr), 64'(head_instr));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    $display("[TB] reset state");
    check_fetch("rst", 1'b0, 32'h0, 1'b0, 32'h0);
    check_output("rst.id_valid", 64'(id_valid), 64'h0);
    check_output("rst.id_pc", 64'(id_pc), 64'h0);
    check_output("rst.id_instr", 64'(id_instr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] sequential fetch, same-cycle ack");
    apply_stimulus(1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b1);
    check_fetch("A", 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004);
    check_id("A", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b1);
    check_fetch("B", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008);
    check_id("B", 1'b1, 32'h0000_0000, 32'h1111_0000);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h1111_0008, 1'b0, 32'h0, 1'b1);
    check_fetch("C", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_000C);
    check_id("C", 1'b1, 32'h0000_0004, 32'h1111_0004);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h1111_000C, 1'b0, 32'h0, 1'b1);
    check_fetch("D", 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0010);
    check_id("D", 1'b1, 32'h0000_0008, 32'h1111_0008);
    @(negedge clk);

    $display("[TB] redirect while outstanding");
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_fetch("E", 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    check_id("E", 1'b1, 32'h0000_000C, 32'h1111_000C);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
    check_fetch("F", 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0100);
    check_id("F", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_fetch("G", 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    check_output("G.pc", 64'(pc), 64'h0000_0100);
    check_id("G", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    check_fetch("H", 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    check_id("H", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h2222_0100, 1'b0, 32'h0, 1'b1);
    check_fetch("I", 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0104);
    check_id("I", 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("[TB] backpressure with one-cycle ack latency");
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_fetch("J", 1'b1, 32'h0000_0104, 1'b0, 32'h0);
    check_id("J", 1'b1, 32'h0000_0100, 32'h2222_0100);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h2222_0104, 1'b0, 32'h0, 1'b0);
    check_fetch("K", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0108);
    check_id("K", 1'b1, 32'h0000_0100, 32'h2222_0100);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_fetch("L", 1'b0, 32'h0000_0108, 1'b0, 32'h0);
    check_id("L", 1'b1, 32'h0000_0100, 32'h2222_0100);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_fetch("M", 1'b0, 32'h0000_0108, 1'b0, 32'h0);
    check_id("M", 1'b1, 32'h0000_0100, 32'h2222_0100);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_fetch("N", 1'b1, 32'h0000_0108, 1'b0, 32'h0);
    check_id("N", 1'b1, 32'h0000_0104, 32'h2222_0104);
    @(negedge clk);

    $display("[TB] redirect coincident with ack");
    apply_stimulus(1'b1, 32'h2222_0108, 1'b1, 32'h0000_0040, 1'b1);
    check_fetch("O", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0040);
    check_id("O", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h3333_0040, 1'b0, 32'h0, 1'b1);
    check_fetch("P", 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0044);
    check_id("P", 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("[TB] redirect to top of address space and wrap");
    apply_stimulus(1'b1, 32'h3333_0044, 1'b1, 32'hFFFF_FFFE, 1'b1);
    check_fetch("Q", 1'b1, 32'h0000_0044, 1'b1, 32'hFFFF_FFFC);
    check_id("Q", 1'b1, 32'h0000_0040, 32'h3333_0040);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h4444_00FC, 1'b0, 32'h0, 1'b1);
    check_fetch("R", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);
    check_id("R", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_fetch("S", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
    check_id("S", 1'b1, 32'hFFFF_FFFC, 32'h4444_00FC);
    @(negedge clk);

    $display("[TB] reset during an outstanding request");
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_fetch("T", 1'b0, 32'h0000_0000, 1'b0, 32'h0);
    check_id("T", 1'b0, 32'h0, 32'h0);
    check_output("T.id_pc", 64'(id_pc), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h5555_0000, 1'b0, 32'h0, 1'b1);
    check_fetch("U", 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004);
    check_id("U", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_fetch("V", 1'b1, 32'h0000_0004, 1'b0, 32'h0);
    check_id("V", 1'b1, 32'h0000_0000, 32'h5555_0000);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
